// File: rtl/isp_demosaic_seq_pkg.sv
// Shared definitions for the demosaic front end: Bayer pattern codes,
// sequencer state encoding and the synthetic-line phase encoding.
package isp_demosaic_seq_pkg;

    // Bayer pattern codes, shared with the demosaic stage
    typedef enum logic [1:0] {
        BAYER_RGGB = 2'd0,
        BAYER_GRBG = 2'd1,
        BAYER_GBRG = 2'd2,
        BAYER_BGGR = 2'd3
    } bayer_e;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Synthetic line phase: horizontal blank, then active pixels
    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_LINE  = 1'b1
    } flush_phase_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/isp_demosaic_seq_if.sv
// Raw video stream bundle (sync, line valid, data enable, pixel).
interface isp_demosaic_seq_if #(
    parameter int BITS = 8
);
    logic            vsync;
    logic            href;
    logic            de;
    logic [BITS-1:0] raw;

    modport master (output vsync, href, de, raw);
    modport slave  (input  vsync, href, de, raw);
endinterface

// File: rtl/isp_flush_gen.sv
// Synthetic line generator: on start_i, emits FLUSH_LINES lines, each being
// HBLANK cycles of href low followed by WIDTH cycles of href high. done_o is
// high during the final active cycle of the last line.
module isp_flush_gen
    import isp_demosaic_seq_pkg::*;
#(
    parameter int WIDTH       = 1280,
    parameter int HBLANK      = 16,
    parameter int FLUSH_LINES = 2
) (
    input  logic pclk,
    input  logic rst,
    input  logic start_i,
    output logic href_o,
    output logic done_o
);

    localparam int CNT_W = $clog2(max_int(WIDTH, HBLANK) + 1);
    localparam int LN_W  = $clog2(FLUSH_LINES + 1);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(HBLANK - 1);
    localparam logic [CNT_W-1:0] PIX_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [LN_W-1:0]  LINES_LAST = LN_W'(FLUSH_LINES - 1);

    logic         busy_q,  busy_d;
    flush_phase_e phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LN_W-1:0]  line_q, line_d;

    // Next-state: walk blank -> line -> blank ... until the last line ends
    always_comb begin
        // NOTE: every variable gets a default first, so no path infers a latch.
        busy_d  = busy_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        done_o  = 1'b0;
        if (start_i) begin
            busy_d  = 1'b1;
            phase_d = PH_BLANK;
            cnt_d   = '0;
            line_d  = '0;
        end else if (busy_q) begin
            if (phase_q == PH_BLANK) begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    phase_d = PH_LINE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == PIX_LAST) begin
                    cnt_d   = '0;
                    phase_d = PH_BLANK;
                    if (line_q == LINES_LAST) begin
                        busy_d = 1'b0;
                        done_o = 1'b1;
                    end else begin
                        line_d = line_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge pclk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            busy_q  <= 1'b0;
            phase_q <= PH_BLANK;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
        end
    end

    assign href_o = busy_q && (phase_q == PH_LINE);

endmodule

// File: rtl/isp_demosaic_seq.sv
// Frame sequencer ahead of the Bayer demosaic: registers the raw stream,
// checks frame geometry, applies config only at frame boundaries and appends
// synthetic flush lines so the demosaic line buffer drains the last rows.
module isp_demosaic_seq
    import isp_demosaic_seq_pkg::*;
#(
    parameter int BITS        = 8,
    parameter int WIDTH       = 1280,
    parameter int HEIGHT      = 960,
    parameter int FLUSH_LINES = 2,
    parameter int HBLANK      = 16
) (
    input  logic                pclk,
    input  logic                rst,
    isp_demosaic_seq_if.slave   in_if,
    isp_demosaic_seq_if.master  out_if,
    input  logic                cfg_valid,
    input  logic [1:0]          cfg_bayer,
    input  logic                cfg_bypass,
    output logic [1:0]          dm_bayer,
    output logic                dm_bypass,
    output logic                frame_start,
    output logic                frame_done,
    output logic                err_geom,
    output logic                err_overrun
);

    localparam int PIX_W  = $clog2(WIDTH + 1);
    localparam int LINE_W = $clog2(HEIGHT + 1);

    localparam logic [PIX_W-1:0]  PIX_MAX   = PIX_W'(WIDTH);
    localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(HEIGHT);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(HEIGHT - 1);

    state_e state_q, state_d;

    // Input stream delayed one cycle; also serves as edge-detect history
    logic            vsync_q, href_q, de_q;
    logic [BITS-1:0] raw_q;

    logic [PIX_W-1:0]  pix_cnt_q,  pix_cnt_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;

    bayer_e pend_bayer_q, act_bayer_q;
    logic   pend_bypass_q, act_bypass_q;

    logic frame_start_q, frame_start_d;
    logic frame_done_q,  frame_done_d;
    logic err_geom_q,    err_geom_d;
    logic err_overrun_q, err_overrun_d;

    logic flush_start, flush_done, syn_href;
    logic href_rise, href_fall, vsync_rise, flushing;

    assign href_rise  = in_if.href  & ~href_q;
    assign href_fall  = ~in_if.href & href_q;
    assign vsync_rise = in_if.vsync & ~vsync_q;
    assign flushing   = (state_q == ST_FLUSH);

    isp_flush_gen #(
        .WIDTH       (WIDTH),
        .HBLANK      (HBLANK),
        .FLUSH_LINES (FLUSH_LINES)
    ) u_flush_gen (
        .pclk    (pclk),
        .rst     (rst),
        .start_i (flush_start),
        .href_o  (syn_href),
        .done_o  (flush_done)
    );

    // Sequencer next-state, geometry counters and status pulses
    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        err_geom_d    = err_geom_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        err_overrun_d = 1'b0;
        flush_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (href_rise) begin
                    state_d       = ST_ACTIVE;
                    frame_start_d = 1'b1;
                    err_geom_d    = 1'b0;
                    pix_cnt_d     = in_if.de ? PIX_W'(1) : '0;
                    line_cnt_d    = '0;
                end
            end
            ST_ACTIVE: begin
                if (in_if.href && in_if.de && (pix_cnt_q != PIX_MAX)) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
                if (href_fall) begin
                    pix_cnt_d = '0;
                    if (pix_cnt_q != PIX_MAX) begin
                        err_geom_d = 1'b1;
                    end
                    if (line_cnt_q != LINE_MAX) begin
                        line_cnt_d = line_cnt_q + 1'b1;
                    end
                end
                // A completing line wins over a coincident vsync rise
                if (href_fall && (line_cnt_q == LINE_LAST)) begin
                    state_d     = ST_FLUSH;
                    flush_start = 1'b1;
                end else if (vsync_rise && (line_cnt_q < LINE_MAX)) begin
                    err_geom_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (href_rise) begin
                    err_overrun_d = 1'b1;
                end
                if (flush_done) begin
                    state_d      = ST_DONE;
                    frame_done_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, counters and status registers
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            err_geom_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            err_geom_q    <= err_geom_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    // One-cycle passthrough of the raw stream
    always_ff @(posedge pclk) begin
        if (rst) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            de_q    <= 1'b0;
            raw_q   <= '0;
        end else begin
            vsync_q <= in_if.vsync;
            href_q  <= in_if.href;
            de_q    <= in_if.de;
            raw_q   <= in_if.raw;
        end
    end

    // Pending config, promoted to active only on a vsync rise while idle
    always_ff @(posedge pclk) begin
        if (rst) begin
            pend_bayer_q  <= BAYER_RGGB;
            pend_bypass_q <= 1'b0;
            act_bayer_q   <= BAYER_RGGB;
            act_bypass_q  <= 1'b0;
        end else begin
            if (cfg_valid) begin
                pend_bayer_q  <= bayer_e'(cfg_bayer);
                pend_bypass_q <= cfg_bypass;
            end
            if ((state_q == ST_IDLE) && vsync_rise) begin
                act_bayer_q  <= cfg_valid ? bayer_e'(cfg_bayer) : pend_bayer_q;
                act_bypass_q <= cfg_valid ? cfg_bypass : pend_bypass_q;
            end
        end
    end

    assign out_if.vsync = vsync_q;
    assign out_if.href  = flushing ? syn_href : href_q;
    assign out_if.de    = flushing ? syn_href : de_q;
    assign out_if.raw   = flushing ? '0 : raw_q;

    assign dm_bayer    = act_bayer_q;
    assign dm_bypass   = act_bypass_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign err_geom    = err_geom_q;
    assign err_overrun = err_overrun_q;

endmodule
